id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
Decode/execute pipeline register for the 16-bit, 8-register RISC core. It sits directly downstream of the forwarding unit and consumes its per-operand forwarded value and select. It detects load-use hazards, stalls decode for one cycle and inserts a bubble, handles branch flush and external hold, and keeps a saturating stall-cycle counter.

Parameters:
DATA_W, 16, operand/immediate width
ADDR_W, 3, register address width (8 registers)
OP_W, 4, ALU opcode width
CNT_W, 16, stall counter width

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst_n  in  1  synchronous, active-low reset
dec_valid  in  1  decode slot holds a real instruction
dec_src1_addr, dec_src2_addr  in  ADDR_W  source register addresses
dec_use1, dec_use2  in  1  the instruction actually reads src1/src2
dec_src1_val, dec_src2_val  in  DATA_W  register-file read values
dec_dst_addr  in  ADDR_W  destination register
dec_wb  in  1  instruction writes back
dec_mem_read  in  1  instruction is a load
dec_alu_op  in  OP_W  ALU operation
dec_imm  in  DATA_W  immediate
fwd_ctrl1, fwd_ctrl2  in  1  forwarding unit override select per operand
fwd_result1, fwd_result2  in  DATA_W  forwarded values
flush  in  1  taken branch resolved in execute; kill EX contents
hold  in  1  downstream (memory) busy; freeze the stage
ex_valid, ex_wb, ex_mem_read  out  1  registered control
ex_src1_val, ex_src2_val, ex_imm  out  DATA_W  registered operands
ex_dst_addr  out  ADDR_W  registered destination
ex_alu_op  out  OP_W  registered opcode
stall  out  1  combinational; freeze PC and IF/ID
stall_count  out  CNT_W  cycles in which load-use stall fired, saturating

Behaviour:
- Reset (rst_n=0 at a clock edge): every registered output is 0, stall_count is 0. A zero-filled stage is a bubble. stall is 0 while rst_n=0.
- Operand capture: ex_srcN_val <= fwd_ctrlN ? fwd_resultN : dec_srcN_val. All other fields are copied unchanged. Latency is 1 cycle.
- Load-use hazard (combinational), lu = ex_valid & ex_mem_read & ex_wb & dec_valid & ((dec_use1 & dec_src1_addr==ex_dst_addr) | (dec_use2 & dec_src2_addr==ex_dst_addr)).
- stall = (lu | hold) & ~flush & rst_n.
- Per-edge priority, highest first:
  1. reset.
  2. flush: load a bubble (ex_valid, ex_wb, ex_mem_read = 0; data fields 0). lu and hold are ignored. The counter does not increment.
  3. hold: all ex_* registers keep their value. No bubble. The counter does not increment, even if lu is true.
  4. lu: load a bubble and increment stall_count. Decode is held by stall, so the same instruction is presented again next cycle. With the load now in the memory stage, lu is false and forwarding supplies the value.
  5. Otherwise normal capture. If dec_valid=0, capture it as a bubble: ex_wb and ex_mem_read are forced to 0.
- A load followed by a load-dependent load stalls exactly once per dependence.
- A hazard on both operands still costs one bubble only.
- stall_count saturates at all-ones and does not wrap.
- Deasserting rst_n mid-stall clears everything. The next cycle, with rst_n=1, starts from the bubble state.

Decomposition:
- Package cpu_pkg: DATA_W, ADDR_W, OP_W, the ALU opcode constants, and a BUBBLE constant (all-zero control bundle) shared with the EX/MEM and MEM/WB registers.
- One sub-module, load_use_detect: purely combinational. Takes the ex_* and dec_* fields and outputs lu.

Test Plan:
- Reset: hold rst_n=0 two cycles with random inputs -> all ex_* outputs = 0, stall_count = 0, stall = 0.
- Forwarding capture: dec_src1_val=0x1111, fwd_ctrl1=1, fwd_result1=0xBEEF, fwd_ctrl2=0, dec_src2_val=0x0042 -> next cycle ex_src1_val=0xBEEF, ex_src2_val=0x0042, ex_valid=1.
- Load-use: load to R3 in EX, then decode has dec_use2=1 with src2=R3 -> stall=1 for exactly one cycle, ex_valid=0 the next cycle, stall_count=1. The cycle after, the instruction is captured normally.
- No false hazard: same as the load-use case but dec_use2=0, or EX holds a non-load writing R3 -> stall=0 and no bubble.
- Flush and hold together: flush=1, hold=1, lu=1 -> stall=0, ex_valid=0 next cycle, stall_count unchanged.
- Hold: EX holds ALU op 0x5, hold=1 for 3 cycles -> ex_* unchanged, stall=1. Counter saturation: with CNT_W=2, 5 consecutive load-use stalls -> stall_count=3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Widths, ALU opcodes and the pipeline control bundle shared by the pipeline registers
// of the 16-bit, 8-register core.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] AluAdd  = 4'h0;
  localparam logic [OP_W-1:0] AluSub  = 4'h1;
  localparam logic [OP_W-1:0] AluAnd  = 4'h2;
  localparam logic [OP_W-1:0] AluOr   = 4'h3;
  localparam logic [OP_W-1:0] AluXor  = 4'h4;
  localparam logic [OP_W-1:0] AluSll  = 4'h5;
  localparam logic [OP_W-1:0] AluSrl  = 4'h6;
  localparam logic [OP_W-1:0] AluSra  = 4'h7;
  localparam logic [OP_W-1:0] AluSlt  = 4'h8;
  localparam logic [OP_W-1:0] AluPass = 4'h9;

  typedef struct packed {
    logic valid;
    logic wb;
    logic mem_read;
  } ctrl_t;

  // An all-zero control bundle is a bubble in every pipeline register.
  localparam ctrl_t BUBBLE = '0;

  // Side effects of an empty decode slot must never reach later stages.
  function automatic ctrl_t capture_ctrl(input logic valid, input logic wb,
                                         input logic mem_read);
    ctrl_t c;
    c.valid    = valid;
    c.wb       = valid & wb;
    c.mem_read = valid & mem_read;
    return c;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags an instruction in decode that reads the destination of a load still in execute.
module load_use_detect
  import cpu_pkg::*;
(
  input  logic              ex_valid_i,
  input  logic              ex_wb_i,
  input  logic              ex_mem_read_i,
  input  logic [ADDR_W-1:0] ex_dst_addr_i,
  input  logic              dec_valid_i,
  input  logic              dec_use1_i,
  input  logic [ADDR_W-1:0] dec_src1_addr_i,
  input  logic              dec_use2_i,
  input  logic [ADDR_W-1:0] dec_src2_addr_i,
  output logic              lu_o
);

  logic ex_is_load;
  logic hit1;
  logic hit2;

  always_comb begin
    ex_is_load = ex_valid_i & ex_mem_read_i & ex_wb_i;
    hit1       = dec_use1_i & (dec_src1_addr_i == ex_dst_addr_i);
    hit2       = dec_use2_i & (dec_src2_addr_i == ex_dst_addr_i);
    // Both operands hitting still yields a single hazard, hence a single bubble.
    lu_o       = ex_is_load & dec_valid_i & (hit1 | hit2);
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode/execute pipeline register: forwarded operand capture, load-use stall with bubble
// insertion, branch flush, downstream hold and a saturating stall-cycle counter.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  input  logic [ADDR_W-1:0] dec_src1_addr,
  input  logic [ADDR_W-1:0] dec_src2_addr,
  input  logic              dec_use1,
  input  logic              dec_use2,
  input  logic [DATA_W-1:0] dec_src1_val,
  input  logic [DATA_W-1:0] dec_src2_val,
  input  logic [ADDR_W-1:0] dec_dst_addr,
  input  logic              dec_wb,
  input  logic              dec_mem_read,
  input  logic [OP_W-1:0]   dec_alu_op,
  input  logic [DATA_W-1:0] dec_imm,
  input  logic              fwd_ctrl1,
  input  logic              fwd_ctrl2,
  input  logic [DATA_W-1:0] fwd_result1,
  input  logic [DATA_W-1:0] fwd_result2,
  input  logic              flush,
  input  logic              hold,
  output logic              ex_valid,
  output logic              ex_wb,
  output logic              ex_mem_read,
  output logic [DATA_W-1:0] ex_src1_val,
  output logic [DATA_W-1:0] ex_src2_val,
  output logic [DATA_W-1:0] ex_imm,
  output logic [ADDR_W-1:0] ex_dst_addr,
  output logic [OP_W-1:0]   ex_alu_op,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] src1_q, src1_d;
  logic [DATA_W-1:0] src2_q, src2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              lu;
  logic [DATA_W-1:0] opnd1;
  logic [DATA_W-1:0] opnd2;

  load_use_detect u_load_use_detect (
    .ex_valid_i      (ctrl_q.valid),
    .ex_wb_i         (ctrl_q.wb),
    .ex_mem_read_i   (ctrl_q.mem_read),
    .ex_dst_addr_i   (dst_q),
    .dec_valid_i     (dec_valid),
    .dec_use1_i      (dec_use1),
    .dec_src1_addr_i (dec_src1_addr),
    .dec_use2_i      (dec_use2),
    .dec_src2_addr_i (dec_src2_addr),
    .lu_o            (lu)
  );

  // A flush kills the instruction that caused the stall, so it overrides both stall sources.
  assign stall = (lu | hold) & ~flush & rst_n;

  always_comb begin
    opnd1 = fwd_ctrl1 ? fwd_result1 : dec_src1_val;
    opnd2 = fwd_ctrl2 ? fwd_result2 : dec_src2_val;
  end

  always_comb begin
    ctrl_d = ctrl_q;
    src1_d = src1_q;
    src2_d = src2_q;
    imm_d  = imm_q;
    dst_d  = dst_q;
    op_d   = op_q;
    cnt_d  = cnt_q;

    if (flush) begin
      ctrl_d = BUBBLE;
      src1_d = '0;
      src2_d = '0;
      imm_d  = '0;
      dst_d  = '0;
      op_d   = '0;
    end else if (hold) begin
      // Frozen stage: a pending load-use hazard is resolved once hold drops.
    end else if (lu) begin
      ctrl_d = BUBBLE;
      src1_d = '0;
      src2_d = '0;
      imm_d  = '0;
      dst_d  = '0;
      op_d   = '0;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      ctrl_d = capture_ctrl(dec_valid, dec_wb, dec_mem_read);
      src1_d = opnd1;
      src2_d = opnd2;
      imm_d  = dec_imm;
      dst_d  = dec_dst_addr;
      op_d   = dec_alu_op;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q <= BUBBLE;
      src1_q <= '0;
      src2_q <= '0;
      imm_q  <= '0;
      dst_q  <= '0;
      op_q   <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      src1_q <= src1_d;
      src2_q <= src2_d;
      imm_q  <= imm_d;
      dst_q  <= dst_d;
      op_q   <= op_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ex_valid    = ctrl_q.valid;
  assign ex_wb       = ctrl_q.wb;
  assign ex_mem_read = ctrl_q.mem_read;
  assign ex_src1_val = src1_q;
  assign ex_src2_val = src2_q;
  assign ex_imm      = imm_q;
  assign ex_dst_addr = dst_q;
  assign ex_alu_op   = op_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hold/saturation sequences and
// randomized traffic against a behavioural model of the stage.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid, dec_use1, dec_use2, dec_wb, dec_mem_read;
  logic [2:0]  dec_src1_addr, dec_src2_addr, dec_dst_addr;
  logic [15:0] dec_src1_val, dec_src2_val, dec_imm, fwd_result1, fwd_result2;
  logic [3:0]  dec_alu_op;
  logic        fwd_ctrl1, fwd_ctrl2, flush, hold;

  logic        ex_valid, ex_wb, ex_mem_read, stall;
  logic [15:0] ex_src1_val, ex_src2_val, ex_imm, stall_count;
  logic [2:0]  ex_dst_addr;
  logic [3:0]  ex_alu_op;

  logic        s_valid, s_wb, s_mem_read, s_stall;
  logic [15:0] s_src1_val, s_src2_val, s_imm;
  logic [2:0]  s_dst_addr;
  logic [3:0]  s_alu_op;
  logic [1:0]  s_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage u_dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_src1_addr(dec_src1_addr),
    .dec_src2_addr(dec_src2_addr), .dec_use1(dec_use1), .dec_use2(dec_use2),
    .dec_src1_val(dec_src1_val), .dec_src2_val(dec_src2_val), .dec_dst_addr(dec_dst_addr),
    .dec_wb(dec_wb), .dec_mem_read(dec_mem_read), .dec_alu_op(dec_alu_op), .dec_imm(dec_imm),
    .fwd_ctrl1(fwd_ctrl1), .fwd_ctrl2(fwd_ctrl2), .fwd_result1(fwd_result1),
    .fwd_result2(fwd_result2), .flush(flush), .hold(hold), .ex_valid(ex_valid), .ex_wb(ex_wb),
    .ex_mem_read(ex_mem_read), .ex_src1_val(ex_src1_val), .ex_src2_val(ex_src2_val),
    .ex_imm(ex_imm), .ex_dst_addr(ex_dst_addr), .ex_alu_op(ex_alu_op), .stall(stall),
    .stall_count(stall_count)
  );

  id_ex_stage #(.CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_src1_addr(dec_src1_addr),
    .dec_src2_addr(dec_src2_addr), .dec_use1(dec_use1), .dec_use2(dec_use2),
    .dec_src1_val(dec_src1_val), .dec_src2_val(dec_src2_val), .dec_dst_addr(dec_dst_addr),
    .dec_wb(dec_wb), .dec_mem_read(dec_mem_read), .dec_alu_op(dec_alu_op), .dec_imm(dec_imm),
    .fwd_ctrl1(fwd_ctrl1), .fwd_ctrl2(fwd_ctrl2), .fwd_result1(fwd_result1),
    .fwd_result2(fwd_result2), .flush(flush), .hold(hold), .ex_valid(s_valid), .ex_wb(s_wb),
    .ex_mem_read(s_mem_read), .ex_src1_val(s_src1_val), .ex_src2_val(s_src2_val),
    .ex_imm(s_imm), .ex_dst_addr(s_dst_addr), .ex_alu_op(s_alu_op), .stall(s_stall),
    .stall_count(s_count)
  );

  // Behavioural model: what the execute slot should hold and how many stalls were charged.
  bit          m_valid, m_wb, m_mr;
  logic [15:0] m_s1, m_s2, m_imm;
  logic [2:0]  m_dst;
  logic [3:0]  m_op;
  int          m_cnt, m_cnt2;
  logic        stall_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit reads_reg(input logic [2:0] r);
    return (dec_use1 && dec_src1_addr == r) || (dec_use2 && dec_src2_addr == r);
  endfunction

  function automatic bit model_lu();
    return m_valid && m_mr && m_wb && dec_valid && reads_reg(m_dst);
  endfunction

  function automatic bit model_stall();
    return rst_n && !flush && (model_lu() || hold);
  endfunction

  task automatic model_clear();
    m_valid = 0; m_wb = 0; m_mr = 0;
    m_s1 = '0; m_s2 = '0; m_imm = '0; m_dst = '0; m_op = '0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_clear();
      m_cnt = 0;
      m_cnt2 = 0;
    end else if (flush) begin
      model_clear();
    end else if (hold) begin
      // nothing moves
    end else if (model_lu()) begin
      model_clear();
      m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : 65535;
      m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : 3;
    end else begin
      m_valid = dec_valid;
      m_wb    = dec_valid && dec_wb;
      m_mr    = dec_valid && dec_mem_read;
      m_s1    = fwd_ctrl1 ? fwd_result1 : dec_src1_val;
      m_s2    = fwd_ctrl2 ? fwd_result2 : dec_src2_val;
      m_imm   = dec_imm;
      m_dst   = dec_dst_addr;
      m_op    = dec_alu_op;
    end
  endtask

  // Inputs are already applied; samples stall mid-cycle, clocks once, optionally compares.
  task automatic tick(input bit cmp);
    bit exp_stall;
    #2;
    stall_seen = stall;
    exp_stall = model_stall();
    if (cmp) chk("stall", {31'd0, stall}, {31'd0, exp_stall});
    model_edge();
    @(posedge clk);
    #1;
    if (cmp) begin
      chk("ex_ctrl", {29'd0, ex_valid, ex_wb, ex_mem_read}, {29'd0, m_valid, m_wb, m_mr});
      chk("ex_src1_val", {16'd0, ex_src1_val}, {16'd0, m_s1});
      chk("ex_src2_val", {16'd0, ex_src2_val}, {16'd0, m_s2});
      chk("ex_imm_dst_op", {9'd0, ex_imm, ex_dst_addr, ex_alu_op}, {9'd0, m_imm, m_dst, m_op});
      chk("stall_count", {16'd0, stall_count}, m_cnt);
      chk("stall_count_sat", {30'd0, s_count}, m_cnt2);
    end
  endtask

  typedef struct packed {
    logic        rst, flush, hold, valid, use1, use2, wb, mr, fc1, fc2;
    logic [2:0]  s1a, s2a, dst;
    logic [3:0]  op;
    logic [15:0] s1v, s2v, imm, fr1, fr2;
    logic        e_stall, e_valid, e_wb, e_mr;
    logic [15:0] e_s1, e_s2, e_cnt;
  } vec_t;

  vec_t tbl[19];

  task automatic apply(input vec_t v);
    rst_n = !v.rst; flush = v.flush; hold = v.hold; dec_valid = v.valid;
    dec_use1 = v.use1; dec_use2 = v.use2; dec_wb = v.wb; dec_mem_read = v.mr;
    fwd_ctrl1 = v.fc1; fwd_ctrl2 = v.fc2; dec_src1_addr = v.s1a; dec_src2_addr = v.s2a;
    dec_dst_addr = v.dst; dec_alu_op = v.op; dec_src1_val = v.s1v; dec_src2_val = v.s2v;
    dec_imm = v.imm; fwd_result1 = v.fr1; fwd_result2 = v.fr2;
  endtask

  task automatic set_instr(input bit valid, input bit wb, input bit mr, input logic [2:0] dst,
                           input bit u1, input logic [2:0] a1, input bit u2,
                           input logic [2:0] a2);
    vec_t v;
    v = '0;
    v.valid = valid; v.wb = wb; v.mr = mr; v.dst = dst;
    v.use1 = u1; v.s1a = a1; v.use2 = u2; v.s2a = a2;
    apply(v);
  endtask

  initial begin
    logic [3:0]  hold_op;
    logic [15:0] hold_imm;

    // Reset rows carry busy-looking inputs; stall must still read 0.
    tbl[0]  = '{rst:1, hold:1, valid:1, use1:1, s1a:3, wb:1, mr:1, dst:3, s1v:16'hffff,
                s2v:16'h1234, fc1:1, fr1:16'hdead, op:7, imm:16'h55aa, default:0};
    tbl[1]  = '{rst:1, valid:1, wb:1, mr:1, dst:3, use2:1, s2a:3, s1v:16'h0a0a, default:0};
    tbl[2]  = '{valid:1, use1:1, s1a:2, s1v:16'h1111, fc1:1, fr1:16'hbeef, s2v:16'h0042,
                wb:1, dst:1, op:1, e_valid:1, e_wb:1, e_s1:16'hbeef, e_s2:16'h0042,
                default:0};
    tbl[3]  = '{valid:1, wb:1, mr:1, dst:3, s1v:16'h0100, e_valid:1, e_wb:1, e_mr:1,
                e_s1:16'h0100, default:0};
    tbl[4]  = '{valid:1, use2:1, s2a:3, s2v:16'h0007, s1v:16'h0005, wb:1, dst:4, op:1,
                e_stall:1, e_cnt:1, default:0};
    tbl[5]  = '{valid:1, use2:1, s2a:3, s2v:16'h0007, s1v:16'h0005, wb:1, dst:4, op:1,
                fc2:1, fr2:16'hcafe, e_valid:1, e_wb:1, e_s1:16'h0005, e_s2:16'hcafe,
                e_cnt:1, default:0};
    tbl[6]  = '{valid:1, wb:1, mr:1, dst:3, s1v:16'h0200, e_valid:1, e_wb:1, e_mr:1,
                e_s1:16'h0200, e_cnt:1, default:0};
    tbl[7]  = '{valid:1, s2a:3, use1:1, s1a:1, wb:1, dst:3, s1v:16'h0011, s2v:16'h0022,
                e_valid:1, e_wb:1, e_s1:16'h0011, e_s2:16'h0022, e_cnt:1, default:0};
    tbl[8]  = '{valid:1, use2:1, s2a:3, wb:1, mr:1, dst:3, s1v:16'h0033, s2v:16'h0044,
                e_valid:1, e_wb:1, e_mr:1, e_s1:16'h0033, e_s2:16'h0044, e_cnt:1, default:0};
    tbl[9]  = '{valid:1, use1:1, s1a:3, flush:1, hold:1, s1v:16'h0077, e_cnt:1, default:0};
    tbl[10] = '{wb:1, mr:1, dst:2, s1v:16'h0055, s2v:16'h0066, e_s1:16'h0055,
                e_s2:16'h0066, e_cnt:1, default:0};
    tbl[11] = '{valid:1, wb:1, mr:1, dst:5, s1v:16'h0a0a, s2v:16'h0b0b, e_valid:1, e_wb:1,
                e_mr:1, e_s1:16'h0a0a, e_s2:16'h0b0b, e_cnt:1, default:0};
    tbl[12] = '{valid:1, use1:1, use2:1, s1a:5, s2a:5, wb:1, dst:6, e_stall:1, e_cnt:2,
                default:0};
    tbl[13] = '{valid:1, use1:1, use2:1, s1a:5, s2a:5, wb:1, dst:6, fc1:1, fr1:16'h1234,
                fc2:1, fr2:16'h5678, e_valid:1, e_wb:1, e_s1:16'h1234, e_s2:16'h5678,
                e_cnt:2, default:0};
    tbl[14] = '{valid:1, wb:1, mr:1, dst:2, s1v:16'h0001, e_valid:1, e_wb:1, e_mr:1,
                e_s1:16'h0001, e_cnt:2, default:0};
    tbl[15] = '{valid:1, wb:1, mr:1, dst:4, use1:1, s1a:2, s1v:16'h0002, e_stall:1,
                e_cnt:3, default:0};
    tbl[16] = '{valid:1, wb:1, mr:1, dst:4, use1:1, s1a:2, s1v:16'h0002, fc1:1,
                fr1:16'h0040, e_valid:1, e_wb:1, e_mr:1, e_s1:16'h0040, e_cnt:3, default:0};
    tbl[17] = '{valid:1, use2:1, s2a:4, wb:1, dst:1, s2v:16'h0009, e_stall:1, e_cnt:4,
                default:0};
    tbl[18] = '{valid:1, use2:1, s2a:4, wb:1, dst:1, s2v:16'h0009, fc2:1, fr2:16'h0099,
                e_valid:1, e_wb:1, e_s2:16'h0099, e_cnt:4, default:0};

    for (int i = 0; i < 19; i++) begin
      apply(tbl[i]);
      tick(1'b0);
      chk($sformatf("tbl%0d_stall", i), {31'd0, stall_seen}, {31'd0, tbl[i].e_stall});
      chk($sformatf("tbl%0d_ctrl", i), {29'd0, ex_valid, ex_wb, ex_mem_read},
          {29'd0, tbl[i].e_valid, tbl[i].e_wb, tbl[i].e_mr});
      chk($sformatf("tbl%0d_src1", i), {16'd0, ex_src1_val}, {16'd0, tbl[i].e_s1});
      chk($sformatf("tbl%0d_src2", i), {16'd0, ex_src2_val}, {16'd0, tbl[i].e_s2});
      chk($sformatf("tbl%0d_count", i), {16'd0, stall_count}, {16'd0, tbl[i].e_cnt});
    end

    // Hold: a load with ALU op 5 sits in EX; decode depends on it but hold wins.
    set_instr(1, 1, 1, 3'd2, 0, 3'd0, 0, 3'd0);
    dec_alu_op = 4'h5; dec_imm = 16'h00aa; dec_src1_val = 16'h0101; dec_src2_val = 16'h0202;
    tick(1'b1);
    hold_op = ex_alu_op;
    hold_imm = ex_imm;
    chk("hold_setup_op", {28'd0, ex_alu_op}, 32'h5);
    for (int i = 0; i < 3; i++) begin
      set_instr(1, 1, 0, 3'd6, 1, 3'd2, 0, 3'd0);
      dec_alu_op = 4'h3; dec_imm = 16'hffff; dec_src1_val = 16'h7777;
      hold = 1'b1;
      tick(1'b1);
      chk("hold_stall", {31'd0, stall_seen}, 32'd1);
      chk("hold_keep", {12'd0, ex_alu_op, ex_imm}, {12'd0, 4'h5, 16'h00aa});
      chk("hold_count", {16'd0, stall_count}, 32'd4);
    end
    hold = 1'b0;
    tick(1'b1);
    chk("after_hold_lu", {31'd0, stall_seen}, 32'd1);
    chk("after_hold_count", {16'd0, stall_count}, 32'd5);

    // Saturation: five load-use stalls after a reset.
    rst_n = 1'b0;
    tick(1'b1);
    for (int i = 0; i < 5; i++) begin
      set_instr(1, 1, 1, 3'd1, 0, 3'd0, 0, 3'd0);
      tick(1'b1);
      set_instr(1, 1, 0, 3'd2, 1, 3'd1, 0, 3'd0);
      tick(1'b1);
      fwd_ctrl1 = 1'b1; fwd_result1 = 16'(i);
      tick(1'b1);
    end
    chk("sat_count16", {16'd0, stall_count}, 32'd5);
    chk("sat_count2", {30'd0, s_count}, 32'd3);

    // Randomized traffic on a narrow register range so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      rst_n         = ($urandom_range(0, 63) != 0);
      flush         = ($urandom_range(0, 7) == 0);
      hold          = ($urandom_range(0, 5) == 0);
      dec_valid     = ($urandom_range(0, 4) != 0);
      dec_use1      = $urandom_range(0, 1);
      dec_use2      = $urandom_range(0, 1);
      dec_wb        = ($urandom_range(0, 3) != 0);
      dec_mem_read  = $urandom_range(0, 1);
      dec_src1_addr = 3'($urandom_range(0, 3));
      dec_src2_addr = 3'($urandom_range(0, 3));
      dec_dst_addr  = 3'($urandom_range(0, 3));
      dec_alu_op    = 4'($urandom);
      dec_src1_val  = 16'($urandom);
      dec_src2_val  = 16'($urandom);
      dec_imm       = 16'($urandom);
      fwd_ctrl1     = $urandom_range(0, 1);
      fwd_ctrl2     = $urandom_range(0, 1);
      fwd_result1   = 16'($urandom);
      fwd_result2   = 16'($urandom);
      tick(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
